twiddle_stream_gen: RTL and testbench

- Parametrised successor to the fixed single-port twiddle ROM.
- Holds the team's standard 128-entry Kyber zeta table: q=3329, Montgomery domain, signed 16-bit.
- Given an NTT stage and a direction, it streams the correct twiddle for every butterfly of that stage, LANES butterflies per beat, over a valid/ready handshake.
- Sits between the NTT controller and the butterfly array; the controller only issues start/stage/inverse.

---
 rtl/twiddle_stream_gen.sv | 171 +++++++++++++++++
 tb/tb_twiddle_stream_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_stream_gen.sv
// Kyber zeta (twiddle) streamer: given an NTT stage and direction, emits the
// twiddle for every butterfly of that stage, LANES per beat, over valid/ready.
module twiddle_stream_gen #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LOG_N = 7,
  parameter int unsigned LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             stage,
  input  logic                   inverse,
  output logic [LANES*WIDTH-1:0] tw,
  output logic                   tw_valid,
  input  logic                   tw_ready,
  output logic [LOG_N-1:0]       tw_beat,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int unsigned BEAT_W = LOG_N - LANE_W;
  localparam int unsigned DEPTH  = 128;

  // Montgomery-domain zetas mod 3329, bit-reversed order
  localparam int ZETAS [DEPTH] = '{
    -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
     -171,   622,  1577,   182,   962, -1202, -1474,  1468,
      573, -1325,   264,   383,  -829,  1458, -1602,  -130,
     -681,  1017,   732,   608, -1542,   411,  -205, -1571,
     1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
      516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
     -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
     -398,   961, -1508,  -725,   448, -1065,   677, -1275,
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e                   state_q, state_d;
  logic [2:0]               stage_q, stage_d;
  logic                     inv_q, inv_d;
  logic [BEAT_W-1:0]        cnt_q, cnt_d;
  logic [LANES*WIDTH-1:0]   tw_q, tw_d;
  logic                     tw_valid_q, tw_valid_d;
  logic [LOG_N-1:0]         tw_beat_q, tw_beat_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic                     advance_c;
  logic [3:0]               shift_c;
  logic [LOG_N-1:0]         base_c;
  logic [LOG_N-1:0]         grp_c  [LANES];
  logic [LOG_N-1:0]         addr_c [LANES];

  assign tw       = tw_q;
  assign tw_valid = tw_valid_q;
  assign tw_beat  = tw_beat_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

  // Per-lane table address; inverse wraps mod 2^LOG_N so stage 6 needs no extra bit
  always_comb begin
    shift_c = 4'(LOG_N) - {1'b0, stage_q};
    base_c  = LOG_N'(1) << stage_q;
    for (int l = 0; l < LANES; l++) begin
      grp_c[l] = ((LOG_N'(cnt_q) << LANE_W) | LOG_N'(l)) >> shift_c;
      if (inv_q) begin
        addr_c[l] = (base_c << 1) - LOG_N'(1) - grp_c[l];
      end else begin
        addr_c[l] = base_c + grp_c[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      stage_q    <= '0;
      inv_q      <= 1'b0;
      cnt_q      <= '0;
      tw_q       <= '0;
      tw_valid_q <= 1'b0;
      tw_beat_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      inv_q      <= inv_d;
      cnt_q      <= cnt_d;
      tw_q       <= tw_d;
      tw_valid_q <= tw_valid_d;
      tw_beat_q  <= tw_beat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state and output-slot loading
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    inv_d      = inv_q;
    cnt_d      = cnt_q;
    tw_d       = tw_q;
    tw_valid_d = tw_valid_q;
    tw_beat_d  = tw_beat_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    advance_c  = !tw_valid_q || tw_ready;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (&stage) begin
            err_d = 1'b1;
          end else begin
            stage_d = stage;
            inv_d   = inverse;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (advance_c) begin
          for (int l = 0; l < LANES; l++) begin
            tw_d[WIDTH*l +: WIDTH] = WIDTH'(ZETAS[addr_c[l]]);
          end
          tw_valid_d = 1'b1;
          tw_beat_d  = LOG_N'(cnt_q);
          cnt_d      = cnt_q + BEAT_W'(1);
          if (&cnt_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (tw_ready) begin
          tw_valid_d = 1'b0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_twiddle_stream_gen.sv
// Bench for twiddle_stream_gen: one LANES=1 and one LANES=2 instance, directed
// streams queued into a scoreboard and checked by a negedge monitor.
module tb_twiddle_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start1, inverse1, ready1, valid1, busy1, done1, err1;
  logic [2:0]  stage1;
  logic [15:0] tw1;
  logic [6:0]  beat1;
  logic        start2, inverse2, ready2, valid2, busy2, done2, err2;
  logic [2:0]  stage2;
  logic [31:0] tw2;
  logic [6:0]  beat2;

  twiddle_stream_gen #(.WIDTH(16), .LOG_N(7), .LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .stage(stage1), .inverse(inverse1),
    .tw(tw1), .tw_valid(valid1), .tw_ready(ready1), .tw_beat(beat1),
    .busy(busy1), .done(done1), .err(err1)
  );

  twiddle_stream_gen #(.WIDTH(16), .LOG_N(7), .LANES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .stage(stage2), .inverse(inverse2),
    .tw(tw2), .tw_valid(valid2), .tw_ready(ready2), .tw_beat(beat2),
    .busy(busy2), .done(done2), .err(err2)
  );

  typedef struct {
    int tw0;
    int tw1;
    int beat;
    bit chk;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc1     = 0;
  int   acc2     = 0;
  bit   last1    = 1'b0;
  bit   last2    = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push1(input int beat, input int v, input bit c);
    exp_t e;
    e.tw0 = v; e.tw1 = v; e.beat = beat; e.chk = c;
    q1.push_back(e);
  endtask

  task automatic push2(input int beat, input int v0, input int v1, input bit c);
    exp_t e;
    e.tw0 = v0; e.tw1 = v1; e.beat = beat; e.chk = c;
    q2.push_back(e);
  endtask

  task automatic go1(input logic [2:0] s, input logic inv);
    stage1 = s; inverse1 = inv; start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
  endtask

  task automatic go2(input logic [2:0] s, input logic inv);
    stage2 = s; inverse2 = inv; start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
  endtask

  task automatic wait_idle(input bit sel, input string name);
    int k = 0;
    while ((sel ? busy2 : busy1) && k < 400) begin
      tick(1);
      k++;
    end
    chk(name, int'(sel ? busy2 : busy1), 0);
  endtask

  task automatic wait_beat1(input int b, input string name);
    int k = 0;
    while (!(valid1 && int'(beat1) == b) && k < 400) begin
      tick(1);
      k++;
    end
    chk(name, int'(beat1), b);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    exp_t em;
    rst = 1'b1;
    start1 = 1'b0; stage1 = '0; inverse1 = 1'b0; ready1 = 1'b1;
    start2 = 1'b0; stage2 = '0; inverse2 = 1'b0; ready2 = 1'b1;

    // Scoreboard monitor: pops on every accepted beat, tracks done timing
    fork
      forever begin
        @(negedge clk);
        chk("done1", int'(done1), int'(last1));
        chk("done2", int'(done2), int'(last2));
        last1 = 1'b0;
        last2 = 1'b0;
        if (!rst && valid1 && ready1) begin
          acc1++;
          if (q1.size() == 0) begin
            chk("unexpected_beat1", int'(beat1), -1);
          end else begin
            em = q1.pop_front();
            chk("beat1", int'(beat1), em.beat);
            if (em.chk) chk("tw1", int'($signed(tw1)), em.tw0);
            if (beat1 == 7'd127) last1 = 1'b1;
          end
        end
        if (!rst && valid2 && ready2) begin
          acc2++;
          if (q2.size() == 0) begin
            chk("unexpected_beat2", int'(beat2), -1);
          end else begin
            em = q2.pop_front();
            chk("beat2", int'(beat2), em.beat);
            if (em.chk) begin
              chk("tw2_lane0", int'($signed(tw2[15:0])), em.tw0);
              chk("tw2_lane1", int'($signed(tw2[31:16])), em.tw1);
            end
            if (beat2 == 7'd63) last2 = 1'b1;
          end
        end
      end
    join_none

    tick(3);
    chk("rst_tw1", int'(tw1), 0);
    chk("rst_valid1", int'(valid1), 0);
    chk("rst_beat1", int'(beat1), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_err1", int'(err1), 0);
    chk("rst_tw2", int'(tw2), 0);
    chk("rst_valid2", int'(valid2), 0);
    rst = 1'b0;
    tick(1);

    // start coinciding with rst is ignored
    rst = 1'b1; start1 = 1'b1; stage1 = 3'd0;
    tick(1);
    rst = 1'b0; start1 = 1'b0;
    chk("rst_start_busy", int'(busy1), 0);
    tick(1);
    chk("rst_start_busy_late", int'(busy1), 0);
    chk("rst_start_valid", int'(valid1), 0);

    // stage 7 -> err pulse only
    go1(3'd7, 1'b0);
    chk("err_pulse", int'(err1), 1);
    chk("err_busy", int'(busy1), 0);
    chk("err_valid", int'(valid1), 0);
    tick(1);
    chk("err_clear", int'(err1), 0);
    chk("err_valid_late", int'(valid1), 0);
    tick(2);

    // forward stage 0: every beat is zeta[1]; restart attempts while busy ignored
    acc1 = 0;
    for (int i = 0; i < 128; i++) push1(i, -758, 1'b1);
    go1(3'd0, 1'b0);
    chk("s0_busy_after_start", int'(busy1), 1);
    chk("s0_no_valid_yet", int'(valid1), 0);
    tick(1);
    chk("s0_first_valid", int'(valid1), 1);
    chk("s0_first_beat", int'(beat1), 0);
    tick(3);
    go1(3'd7, 1'b1);
    chk("busy_start_no_err", int'(err1), 0);
    go1(3'd1, 1'b1);
    chk("busy_start_still_busy", int'(busy1), 1);
    wait_idle(1'b0, "s0_idle");
    chk("s0_queue_empty", q1.size(), 0);
    chk("s0_accepted", acc1, 128);
    tick(2);

    // forward stage 1 with 5-cycle backpressure on beat 10
    acc1 = 0;
    for (int i = 0; i < 128; i++) push1(i, (i < 64) ? -359 : -1517, 1'b1);
    go1(3'd1, 1'b0);
    wait_beat1(10, "bp_reach_beat10");
    ready1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("bp_hold_tw", int'($signed(tw1)), -359);
      chk("bp_hold_beat", int'(beat1), 10);
      chk("bp_hold_valid", int'(valid1), 1);
    end
    ready1 = 1'b1;
    wait_idle(1'b0, "s1_idle");
    chk("s1_queue_empty", q1.size(), 0);
    chk("s1_accepted", acc1, 128);
    tick(2);

    // inverse stage 6: addr = 127 - (j>>1)
    acc1 = 0;
    for (int i = 0; i < 128; i++) begin
      if (i < 2)        push1(i, 1628, 1'b1);
      else if (i < 4)   push1(i, 1522, 1'b1);
      else if (i > 125) push1(i, -1103, 1'b1);
      else              push1(i, 0, 1'b0);
    end
    go1(3'd6, 1'b1);
    wait_idle(1'b0, "inv6_idle");
    chk("inv6_queue_empty", q1.size(), 0);
    chk("inv6_accepted", acc1, 128);
    tick(2);

    // inverse stage 0: every beat is zeta[1]
    acc1 = 0;
    for (int i = 0; i < 128; i++) push1(i, -758, 1'b1);
    go1(3'd0, 1'b1);
    wait_idle(1'b0, "inv0_idle");
    chk("inv0_queue_empty", q1.size(), 0);
    chk("inv0_accepted", acc1, 128);
    tick(2);

    // forward stage 6 on the two-lane instance
    acc2 = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 0)       push2(i, -1103, -1103, 1'b1);
      else if (i == 1)  push2(i, 430, 430, 1'b1);
      else if (i == 32) push2(i, 817, 817, 1'b1);
      else if (i == 63) push2(i, 1628, 1628, 1'b1);
      else              push2(i, 0, 0, 1'b0);
    end
    go2(3'd6, 1'b0);
    wait_idle(1'b1, "l2_idle");
    chk("l2_queue_empty", q2.size(), 0);
    chk("l2_accepted", acc2, 64);
    tick(2);

    // reset mid-stream at beat 40, then a clean restart
    for (int i = 0; i < 128; i++) push1(i, -758, 1'b1);
    go1(3'd0, 1'b0);
    wait_beat1(40, "mid_reach_beat40");
    rst = 1'b1;
    tick(1);
    chk("mid_rst_valid", int'(valid1), 0);
    chk("mid_rst_busy", int'(busy1), 0);
    chk("mid_rst_done", int'(done1), 0);
    rst = 1'b0;
    q1.delete();
    tick(3);
    chk("mid_rst_stay_idle", int'(busy1), 0);
    acc1 = 0;
    for (int i = 0; i < 128; i++) push1(i, -758, 1'b1);
    go1(3'd0, 1'b0);
    tick(1);
    chk("restart_beat0", int'(beat1), 0);
    wait_idle(1'b0, "restart_idle");
    chk("restart_queue_empty", q1.size(), 0);
    chk("restart_accepted", acc1, 128);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
